systolic_result_drain: RTL and testbench

//  Collects the DIMENSION x DIMENSION accumulator results from the systolic PE array.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_result_drain_bank.sv | 53 +++++
 rtl/systolic_result_drain.sv | 115 +++++++++++
 tb/tb_systolic_result_drain.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array result path:
// accumulator width, bank count and flattened PE indexing.
package systolic_pkg;

    localparam int unsigned NUM_BANKS = 2;

    function automatic int unsigned o_bits(input int unsigned i_bits, input int unsigned dimension);
        return 2 * i_bits + $clog2(dimension);
    endfunction

    function automatic int unsigned flat_idx(input int unsigned row, input int unsigned col,
                                             input int unsigned dimension);
        return row * dimension + col;
    endfunction

    // Guarded so a 1x1 array still gets a 1-bit element index.
    function automatic int unsigned idx_bits(input int unsigned dimension);
        return ($clog2(dimension * dimension) > 0) ? $clog2(dimension * dimension) : 1;
    endfunction

endpackage

// File: rtl/systolic_result_drain_bank.sv
// One result bank: DIMENSION^2 accumulator registers plus the capture mask
// recording which PEs have already delivered for the matrix being assembled.
module result_bank
    import systolic_pkg::*;
#(
    parameter int unsigned DIMENSION = 4,
    parameter int unsigned O_BITS    = 18
) (
    input  logic                                  i_clock,
    input  logic                                  i_reset,
    input  logic                                  i_clear,
    input  logic [DIMENSION*DIMENSION-1:0]        i_wr_en,
    input  logic [DIMENSION*DIMENSION*O_BITS-1:0] i_wr_data,
    input  logic [idx_bits(DIMENSION)-1:0]        i_rd_idx,
    output logic [O_BITS-1:0]                     o_rd_data,
    output logic                                  o_all_captured,
    output logic                                  o_dup_hit,
    output logic                                  o_active
);

    localparam int unsigned ELEMS = DIMENSION * DIMENSION;

    logic [O_BITS-1:0] data_q [ELEMS];
    logic [ELEMS-1:0]  mask_q, mask_d;
    logic [ELEMS-1:0]  capture;

    always_comb begin
        capture        = i_wr_en & ~mask_q;
        o_dup_hit      = |(i_wr_en & mask_q);
        o_all_captured = &(mask_q | capture);
        o_active       = |mask_q;
        // Clearing on completion leaves the mask ready for the next matrix.
        mask_d         = i_clear ? '0 : (mask_q | capture);
        o_rd_data      = data_q[i_rd_idx];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    always_ff @(posedge i_clock) begin
        for (int unsigned i = 0; i < ELEMS; i++) begin
            if (capture[i]) begin
                data_q[i] <= i_wr_data[i*O_BITS +: O_BITS];
            end
        end
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Ping-pong collector for systolic PE results: captures per-PE finishes into
// the write bank and streams completed matrices row-major over valid/ready.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int unsigned DIMENSION = 4,
    parameter int unsigned I_BITS    = 8,
    parameter int unsigned O_BITS    = o_bits(I_BITS, DIMENSION)
) (
    input  logic                                  i_clock,
    input  logic                                  i_reset,
    input  logic [DIMENSION*DIMENSION*O_BITS-1:0] i_c_flat,
    input  logic [DIMENSION*DIMENSION-1:0]        i_finish,
    output logic [O_BITS-1:0]                     o_data,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic                                  o_last,
    output logic                                  o_busy,
    output logic                                  o_overrun
);

    localparam int unsigned ELEMS    = DIMENSION * DIMENSION;
    localparam int unsigned IDX_BITS = idx_bits(DIMENSION);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(ELEMS - 1);

    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [NUM_BANKS-1:0] full_q, full_d;
    logic [IDX_BITS-1:0]  rd_idx_q, rd_idx_d;
    logic                 overrun_q, overrun_d;

    logic [ELEMS-1:0]     bank_wr_en   [NUM_BANKS];
    logic [O_BITS-1:0]    bank_rd_data [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_all, bank_dup, bank_active, bank_clear;

    logic wr_full, complete, xfer;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        result_bank #(
            .DIMENSION (DIMENSION),
            .O_BITS    (O_BITS)
        ) u_bank (
            .i_clock        (i_clock),
            .i_reset        (i_reset),
            .i_clear        (bank_clear[b]),
            .i_wr_en        (bank_wr_en[b]),
            .i_wr_data      (i_c_flat),
            .i_rd_idx       (rd_idx_q),
            .o_rd_data      (bank_rd_data[b]),
            .o_all_captured (bank_all[b]),
            .o_dup_hit      (bank_dup[b]),
            .o_active       (bank_active[b])
        );
    end

    // A full write bank means both banks are occupied, so finishes are dropped.
    always_comb begin
        wr_full = full_q[wr_bank_q];
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            bank_wr_en[b] = (wr_bank_q == 1'(b) && !wr_full) ? i_finish : '0;
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            bank_clear[b] = (wr_bank_q == 1'(b)) && !wr_full && bank_all[b];
        end
        complete  = bank_clear[wr_bank_q];
        o_valid   = full_q[rd_bank_q];
        o_last    = o_valid && (rd_idx_q == LAST_IDX);
        o_data    = o_valid ? bank_rd_data[rd_bank_q] : '0;
        o_busy    = (|full_q) || (|bank_active);
        o_overrun = overrun_q;
        xfer      = o_valid && i_ready;
    end

    // Completion and last transfer always target different banks, so both apply.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        rd_idx_d  = rd_idx_q;
        overrun_d = overrun_q | ((|i_finish) && wr_full) | bank_dup[wr_bank_q];
        if (complete) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (xfer) begin
            if (o_last) begin
                rd_idx_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                rd_idx_d = rd_idx_q + IDX_BITS'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
            rd_idx_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            rd_idx_q  <= rd_idx_d;
            overrun_q <= overrun_d;
        end
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain (2x2 array): directed scenarios plus random
// traffic, checked every cycle against a queue-based matrix model.
module tb_systolic_result_drain;

    localparam int unsigned DIM = 2;
    localparam int unsigned N   = DIM * DIM;
    localparam int unsigned OB  = 17;

    logic              i_clock = 1'b0;
    logic              i_reset;
    logic [N*OB-1:0]   i_c_flat;
    logic [N-1:0]      i_finish;
    logic [OB-1:0]     o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_last;
    logic              o_busy;
    logic              o_overrun;

    logic [OB-1:0] c [N];

    always #5 i_clock = ~i_clock;

    always_comb begin
        for (int k = 0; k < N; k++) i_c_flat[k*OB +: OB] = c[k];
    end

    systolic_result_drain #(
        .DIMENSION (DIM),
        .I_BITS    (8),
        .O_BITS    (OB)
    ) dut (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_c_flat  (i_c_flat),
        .i_finish  (i_finish),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_last    (o_last),
        .o_busy    (o_busy),
        .o_overrun (o_overrun)
    );

    // Reference model: partial matrix being assembled, plus a queue of
    // elements from completed matrices awaiting delivery.
    logic [OB-1:0] cap [N];
    bit            got [N];
    logic [OB-1:0] exp_data [$];
    bit            exp_last [$];
    bit            m_ovr;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) got[k] = 0;
        exp_data.delete();
        exp_last.delete();
        m_ovr = 0;
    endtask

    task automatic check_outputs();
        bit any_got;
        bit valid;
        any_got = 0;
        for (int k = 0; k < N; k++) any_got |= got[k];
        valid = exp_data.size() != 0;
        chk("valid",   32'(o_valid),   32'(valid));
        chk("data",    32'(o_data),    valid ? 32'(exp_data[0]) : 32'd0);
        chk("last",    32'(o_last),    valid ? 32'(exp_last[0]) : 32'd0);
        chk("overrun", 32'(o_overrun), 32'(m_ovr));
        chk("busy",    32'(o_busy),    32'(any_got || valid));
    endtask

    task automatic model_update();
        int  pend;
        bit  xfer;
        bit  all;
        if (i_reset) begin
            model_reset();
            return;
        end
        pend = (exp_data.size() + N - 1) / N;
        xfer = (exp_data.size() != 0) && i_ready;
        for (int k = 0; k < N; k++) begin
            if (i_finish[k]) begin
                if (pend == 2 || got[k]) m_ovr = 1;
                else begin
                    cap[k] = c[k];
                    got[k] = 1;
                end
            end
        end
        if (xfer) begin
            void'(exp_data.pop_front());
            void'(exp_last.pop_front());
        end
        all = 1;
        for (int k = 0; k < N; k++) all &= got[k];
        if (all) begin
            for (int k = 0; k < N; k++) begin
                exp_data.push_back(cap[k]);
                exp_last.push_back(k == N - 1);
                got[k] = 0;
            end
        end
    endtask

    task automatic step();
        check_outputs();
        model_update();
        @(posedge i_clock);
        @(negedge i_clock);
    endtask

    task automatic idle(input int n);
        i_finish = '0;
        repeat (n) step();
    endtask

    task automatic fire(input logic [N-1:0] m);
        i_finish = m;
        step();
        i_finish = '0;
    endtask

    task automatic rand_c();
        for (int k = 0; k < N; k++) c[k] = OB'($urandom);
    endtask

    initial begin
        i_reset  = 1'b1;
        i_finish = '0;
        i_ready  = 1'b1;
        for (int k = 0; k < N; k++) c[k] = '0;
        @(posedge i_clock);
        @(negedge i_clock);
        model_reset();
        i_reset = 1'b0;

        // reset state
        idle(2);

        // all four PEs finish together
        c[0] = 17'd1; c[1] = 17'd2; c[2] = 17'd3; c[3] = 17'd4;
        fire(4'hF);
        idle(6);

        // anti-diagonal completion with signed values
        c[0] = -17'sd5; c[1] = 17'sd7; c[2] = -17'sd9; c[3] = 17'sd11;
        fire(4'b0001);
        fire(4'b0110);
        fire(4'b1000);
        idle(6);

        // back-pressure pattern 1,0,0,1
        rand_c();
        fire(4'hF);
        for (int i = 0; i < 16; i++) begin
            i_ready = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        i_ready = 1'b1;
        idle(2);

        // second matrix completes while first is stalled
        i_ready = 1'b0;
        rand_c(); fire(4'hF);
        idle(2);
        rand_c(); fire(4'hF);
        idle(2);
        i_ready = 1'b1;
        idle(10);

        // both banks full, third finish overruns
        i_ready = 1'b0;
        rand_c(); fire(4'hF);
        rand_c(); fire(4'hF);
        rand_c(); fire(4'b0001);
        idle(2);
        i_ready = 1'b1;
        idle(12);

        // reset mid-capture, then a clean matrix
        rand_c(); fire(4'b0011);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        rand_c(); fire(4'hF);
        idle(6);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rand_c();
            for (int k = 0; k < N; k++) i_finish[k] = ($urandom_range(0, 3) == 0);
            i_ready = $urandom_range(0, 2) != 0;
            i_reset = ($urandom_range(0, 149) == 0);
            step();
        end
        i_reset  = 1'b0;
        i_finish = '0;
        i_ready  = 1'b1;
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
